// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks an inclusive, wrapping register range and streams each word over valid/ready; REGDUMP_SKIP_ZERO_EN drops zero words except the last
module regfile_dump_reader #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [4:0]      first_reg,
   input  logic [4:0]      last_reg,
   output logic [4:0]      rf_read_reg,
   input  logic [size-1:0] rf_read_data,
   output logic            dump_valid,
   input  logic            dump_ready,
   output logic [size-1:0] dump_data,
   output logic [4:0]      dump_index,
   output logic            dump_last,
   output logic            busy,
   output logic            done
);
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, SEND = 2'd2, DONE = 2'd3;
   logic [1:0] state;
   logic [4:0] cnt, end_reg;
   logic skip;
`ifdef REGDUMP_SKIP_ZERO_EN
   assign skip = (rf_read_data == '0) && (cnt != end_reg);
`else
   assign skip = 1'b0;
`endif
   assign rf_read_reg = cnt;
   assign busy = (state == READ) || (state == SEND);
   assign dump_valid = state == SEND;
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         end_reg <= '0;
         dump_data <= '0;
         dump_index <= '0;
         dump_last <= 1'b0;
      end else if (abort && busy)
         state <= IDLE;
      else
         case (state)
            IDLE: if (start) begin
               cnt <= first_reg;
               end_reg <= last_reg;
               state <= READ;
            end
            READ: if (skip)
               cnt <= cnt + 5'd1;
            else begin
               dump_data <= rf_read_data;
               dump_index <= cnt;
               dump_last <= cnt == end_reg;
               state <= SEND;
            end
            SEND: if (dump_ready) begin
               state <= dump_last ? DONE : READ;
               if (!dump_last) cnt <= cnt + 5'd1;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: random register contents and ranges checked against an expected-word list built from the range rules
module tb_regfile_dump_reader;
   logic clk = 0, rst_n, start, abort, dump_ready;
   logic [4:0] first_reg, last_reg, rf_read_reg, dump_index;
   logic [31:0] rf_read_data, dump_data;
   logic dump_valid, dump_last, busy, done;
   logic [31:0] rf [32];
   int n_cmp = 0, n_err = 0;
`ifdef REGDUMP_SKIP_ZERO_EN
   localparam bit skip_en = 1'b1;
`else
   localparam bit skip_en = 1'b0;
`endif

   always #5 clk = ~clk;
   assign rf_read_data = rf[rf_read_reg];

   regfile_dump_reader #(.size(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .first_reg(first_reg), .last_reg(last_reg), .rf_read_reg(rf_read_reg),
      .rf_read_data(rf_read_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_data(dump_data), .dump_index(dump_index), .dump_last(dump_last),
      .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready always high, 1: random ready and spurious start, 2: ready low 3 cycles per word
   task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode, input int abort_at);
      logic [4:0] ei[$];
      logic [31:0] ed[$];
      logic el[$];
      logic [4:0] d, a, pi;
      logic [31:0] pd;
      logic pl, rdy, held, fin;
      int n, hs_last, w, got;
      d = l - f;
      n = int'(d) + 1;
      for (int i = 0; i < n; i++) begin
         a = f + 5'(i);
         if (!(skip_en && rf[a] == 0 && i != n - 1)) begin
            ei.push_back(a);
            ed.push_back(rf[a]);
            el.push_back(i == n - 1);
         end
      end
      @(negedge clk);
      first_reg = f;
      last_reg = l;
      start = 1;
      @(negedge clk);
      start = 0;
      chk("busy_at_start", busy, 1);
      chk("rd_addr_at_start", rf_read_reg, f);
      hs_last = -1; w = 0; got = 0; fin = 0; held = 0; pd = 0; pi = 0; pl = 0;
      for (int c = 0; c < 1500 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         chk("done", done, hs_last >= 0 && c == hs_last + 1);
         if (hs_last >= 0 && c == hs_last + 1) begin
            fin = 1;
            if (mode == 0) chk("done_cycle", c, n + ei.size());
            break;
         end
         if (held) begin
            chk("hold_valid", dump_valid, 1);
            chk("hold_data", dump_data, pd);
            chk("hold_index", dump_index, pi);
            chk("hold_last", dump_last, pl);
         end
         rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : w >= 3;
         if (mode == 1) begin
            start = 1'($urandom_range(0, 1));
            first_reg = 5'($urandom);
         end
         if (dump_valid) w++;
         if (abort_at >= 0 && got == abort_at && dump_valid) begin
            abort = 1;
            rdy = 1;
            start = 0;
         end
         dump_ready = rdy;
         held = dump_valid && !rdy;
         pd = dump_data; pi = dump_index; pl = dump_last;
         if (dump_valid && rdy) begin
            if (got < ei.size()) begin
               chk("word_index", dump_index, ei[got]);
               chk("word_data", dump_data, ed[got]);
               chk("word_last", dump_last, el[got]);
               if (el[got]) hs_last = c;
            end else
               chk("extra_word", got, ei.size());
            got++;
            w = 0;
         end
         if (abort) begin
            @(negedge clk);
            abort = 0;
            chk("abort_busy", busy, 0);
            chk("abort_valid", dump_valid, 0);
            chk("abort_count", got, abort_at + 1);
            repeat (6) begin
               @(negedge clk);
               chk("abort_no_done", done, 0);
            end
            fin = 1;
            break;
         end
      end
      start = 0;
      dump_ready = 0;
      chk("finished_in_budget", fin, 1);
      if (abort_at < 0) chk("word_count", got, ei.size());
      @(negedge clk);
      chk("idle_after", busy, 0);
      chk("no_done_after", done, 0);
   endtask

   initial begin
      rst_n = 0; start = 0; abort = 0; dump_ready = 0; first_reg = 0; last_reg = 0;
      for (int i = 0; i < 32; i++) rf[i] = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid", dump_valid, 0);
      chk("rst_data", dump_data, 0);
      chk("rst_index", dump_index, 0);
      chk("rst_last", dump_last, 0);
      chk("rst_rd_addr", rf_read_reg, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1;
      run_dump(5'd0, 5'd31, 0, -1);
      rf[5] = 32'hA5A5A5A5; rf[6] = 32'h1; rf[7] = 32'hFFFFFFFF;
      run_dump(5'd5, 5'd7, 2, -1);
      for (int i = 0; i < 32; i++) rf[i] = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
      run_dump(5'd30, 5'd1, 0, -1);
      run_dump(5'd9, 5'd9, 1, -1);
      run_dump(5'd12, 5'd11, 0, -1);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 32; i++) rf[i] = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
         run_dump(5'($urandom), 5'($urandom), 1, -1);
      end
      for (int i = 0; i < 32; i++) rf[i] = $urandom | 32'h1;
      run_dump(5'd0, 5'd31, 0, 2);
      @(negedge clk);
      first_reg = 0; last_reg = 31; start = 1; dump_ready = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      chk("pre_reset_rd_addr", rf_read_reg, 1);
      chk("pre_reset_busy", busy, 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", dump_valid, 0);
      chk("async_rst_data", dump_data, 0);
      chk("async_rst_index", dump_index, 0);
      chk("async_rst_last", dump_last, 0);
      chk("async_rst_rd_addr", rf_read_reg, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1;
      dump_ready = 0;
      for (int i = 0; i < 32; i++) rf[i] = 0;
      rf[3] = 32'h42;
      run_dump(5'd0, 5'd31, 0, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the 32-entry register file. On a start pulse it walks a programmable, inclusive range of register addresses through one register-file read port. It captures each value and streams it out over a valid/ready interface tagged with its index, for debug dump, trace or scan-out logic. It sits beside the datapath, shares a read port with it, and never drives the register-file write port.

## Interface
Parameters:
- size, 32, data width of each register word; must match the register file.

Ports:
- clk, input, 1, rising-edge clock shared with the register file.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begins a dump; sampled only in IDLE.
- abort, input, 1, terminates an active dump; has priority over all other inputs except rst_n.
- first_reg, input, 5, first address of the range; sampled on the accepted start.
- last_reg, input, 5, last address of the range (inclusive); sampled on the accepted start.
- rf_read_reg, output, 5, address driven to the register-file read port.
- rf_read_data, input, size, combinational read data returned for rf_read_reg.
- dump_valid, output, 1, dump_data, dump_index and dump_last are valid.
- dump_ready, input, 1, consumer accepts the word.
- dump_data, output, size, captured register value.
- dump_index, output, 5, address the value came from.
- dump_last, output, 1, this word is the final word of the range.
- busy, output, 1, high in READ and SEND.
- done, output, 1, one-cycle pulse when the dump completes normally.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE, with start=1 at an edge: latch first_reg into the address counter and last_reg into the end register, then go to READ. When start=0, stay in IDLE.
- READ: rf_read_reg equals the address counter. At the next edge, capture rf_read_data into dump_data and the counter into dump_index. Set dump_last = (counter == end). Go to SEND.
- SEND: dump_valid=1, and all dump_* outputs are held stable until a handshake. A handshake is dump_valid && dump_ready at an edge. On a handshake: if dump_last=1, go to DONE; otherwise increment the counter modulo 32 and go to READ.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Address wrap-around: the counter increments modulo 32. When first_reg > last_reg the walk wraps (for example 30, 31, 0, 1). When first_reg == last_reg exactly one word is emitted. The full range is produced by first_reg = last_reg + 1.
- abort=1 at any edge while busy: go to IDLE and drop dump_valid. done is not pulsed. If a handshake occurs on the same edge, that word counts as delivered and nothing further is sent.
- start while busy or in DONE is ignored.
- The block never writes the register file. A write to the register under read lands or does not land according to register-file timing; data is captured at the READ→SEND edge.

## Timing
- Reset values: dump_valid=0, dump_data=0, dump_index=0, dump_last=0, rf_read_reg=0, busy=0, done=0, state=IDLE. Reset asynchronously clears a dump in progress without a done pulse.
- Start accepted at edge E0: rf_read_reg=first_reg from E0; dump_valid rises after E1 (2-cycle latency).
- Throughput: one word per 2 cycles when dump_ready is held high. N words take 2N cycles from start to the final handshake, and done pulses the cycle after that handshake.
- rf_read_reg holds its last value in SEND, DONE and IDLE.
- dump_ready may be high before valid; it has no combinational path to any output.

## Configuration
- REGDUMP_SKIP_ZERO_EN defined: in READ, if rf_read_data == 0 and the counter is not the end address, no word is emitted. The counter increments and the block stays in READ, so a skip costs 1 cycle. The end address is always emitted, even if zero, so dump_last always appears.
- Undefined: every address in the range is emitted.

## Test plan
- Zero-filled register file, first=0, last=31, dump_ready=1 → 32 words, indices 0..31, data 0, dump_last only on index 31, done 64 cycles after the start edge (plus 1).
- Registers 5..7 written 0xA5A5A5A5, 0x1, 0xFFFFFFFF; range 5..7; dump_ready low for 3 cycles on each word → outputs held stable; words emitted in order; done pulses once.
- first=30, last=1 → indices 30, 31, 0, 1; dump_last on index 1. first=last=9 → a single word with dump_last=1.
- abort asserted in SEND of the 3rd word of range 0..31, with the same-edge handshake → 3 words delivered, done never pulses, busy falls the next cycle. Repeat with rst_n low mid-READ → all outputs are at reset values immediately.
- With REGDUMP_SKIP_ZERO_EN, only reg 3 = 0x42 nonzero, range 0..31 → exactly 2 words: index 3 with data 0x42, and index 31 with data 0 and dump_last=1. Without the macro → 32 words.
